gpio_serial_loader: RTL and testbench
=====================================

GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

Interface
REQ-001 Parameter NUM_IO, default 19, number of GPIO control blocks on the serial chain.
REQ-002 Parameter CFG_BITS, default 13, configuration bits per GPIO control block.
REQ-003 clock  input  1  single block clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset (one clock; reset asynchronous, active-low).
REQ-005 xfer_start  input  1  request to start a full chain transfer; sampled only in IDLE.
REQ-006 cfg_addr  output  $clog2(NUM_IO)  index of the GPIO whose configuration word is requested.
REQ-007 cfg_word  input  CFG_BITS  configuration word for cfg_addr, valid combinationally in the same cycle.
REQ-008 serial_clock  output  1  shift clock to the GPIO control block chain.
REQ-009 serial_load  output  1  latch strobe making the shifted configuration active.
REQ-010 serial_data_out  output  1  serial configuration data to the chain head.
REQ-011 serial_resetn  output  1  chain reset, active-low.
REQ-012 busy  output  1  high while a transfer is in progress.
REQ-013 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-014 States SHALL be IDLE, FETCH, SETUP, HIGH, LATCH, FINISH.
REQ-015 IDLE: io_idx = NUM_IO-1, bit_idx = CFG_BITS-1; xfer_start=1 -> FETCH next cycle, busy=1 from that cycle.
REQ-016 FETCH: shift register <= cfg_word (cfg_addr = io_idx) -> SETUP.
REQ-017 SETUP: serial_data_out = shift register MSB, serial_clock=0 -> HIGH.
REQ-018 HIGH: serial_clock=1, serial_data_out held stable; then bit_idx>0: shift left, bit_idx-1 -> SETUP; bit_idx=0 and io_idx>0: io_idx-1, bit_idx=CFG_BITS-1 -> FETCH; else -> LATCH.
REQ-019 Order: GPIO NUM_IO-1 first, GPIO 0 last; within a word, MSB first.
REQ-020 LATCH: serial_load=1, serial_clock=0 for exactly one cycle -> FINISH.
REQ-021 FINISH: serial_load=0, done=1 for one cycle, busy=0 from the next cycle -> IDLE.
REQ-022 Transfer length SHALL be exactly NUM_IO*(2*CFG_BITS+1)+2 cycles from the first FETCH through FINISH (515 at defaults), with exactly NUM_IO*CFG_BITS serial_clock rising edges.
REQ-023 serial_clock and serial_load SHALL never be high in the same cycle; serial_data_out changes only in cycles where serial_clock=0.
REQ-024 xfer_start while busy=1 SHALL be ignored and not queued; xfer_start in the FINISH cycle is likewise ignored.
REQ-025 All outputs except cfg_addr SHALL be registered; cfg_addr = io_idx register.
REQ-026 Counters SHALL never wrap: io_idx stays within 0..NUM_IO-1 and bit_idx within 0..CFG_BITS-1.

Reset
REQ-027 resetn low SHALL immediately force IDLE, serial_clock=0, serial_load=0, serial_data_out=0, busy=0, done=0, io_idx=NUM_IO-1, bit_idx=CFG_BITS-1.
REQ-028 serial_resetn SHALL assert low asynchronously with resetn and deassert on the first clock edge after resetn rises.
REQ-029 Reset during a transfer SHALL abort it with no serial_load pulse; a new xfer_start is required afterwards.

Structure
REQ-030 Package gpio_serial_loader_pkg SHALL hold the state enumeration and the default NUM_IO/CFG_BITS constants.
REQ-031 Single module; no sub-module is needed. Counters and shift register are inline.

Verification
REQ-032 Defaults; cfg_word = 13'h1000|addr; pulse xfer_start -> 247 serial_clock rises, decoded stream = words 18..0 MSB first, one serial_load pulse, done at cycle 515.
REQ-033 xfer_start held high for the whole transfer -> exactly one transfer, busy falls after done, then a second transfer starts only if xfer_start is still high in IDLE.
REQ-034 resetn low at cycle 200 of a transfer -> all outputs 0, serial_resetn 0, no serial_load; serial_resetn rises one cycle after resetn release.
REQ-035 NUM_IO=2, CFG_BITS=3, words 3'b101, 3'b010 -> serial_data_out at rising edges = 0,1,0,1,0,1; total 16 cycles.
REQ-036 Assertions across all runs: serial_clock&serial_load never high together; serial_data_out stable while serial_clock=1; done is a one-cycle pulse.

Source files
------------

// File: rtl/gpio_serial_loader_pkg.sv
// gpio_serial_loader_pkg: state encoding and default chain geometry shared by the GPIO serial loader.
package gpio_serial_loader_pkg;
  localparam int DEF_NUM_IO   = 19;
  localparam int DEF_CFG_BITS = 13;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETUP, S_HIGH, S_LATCH, S_FINISH} state_t;
endpackage

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: streams each GPIO's configuration word MSB-first down the chain
// (highest GPIO first), then pulses the load strobe to make the new configuration active.
module gpio_serial_loader
  import gpio_serial_loader_pkg::*;
#(
  parameter int NUM_IO   = DEF_NUM_IO,
  parameter int CFG_BITS = DEF_CFG_BITS,
  localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1,
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                xfer_start,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_word,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data_out,
  output logic                serial_resetn,
  output logic                busy,
  output logic                done
);
  localparam logic [AW-1:0] IO_LAST  = AW'(NUM_IO - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_io_idx;
  logic [BW-1:0]       r_bit_idx;
  logic [CFG_BITS-1:0] r_shift, w_shift_nxt;
  logic                w_bit_last, w_io_last;
  logic                w_sclk_nxt, w_load_nxt, w_sdo_nxt, w_busy_nxt, w_done_nxt;

  assign w_bit_last = (r_bit_idx == '0);
  assign w_io_last  = (r_io_idx == '0);
  assign cfg_addr   = r_io_idx;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = xfer_start ? S_FETCH : S_IDLE;
      S_FETCH:  w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_HIGH;
      S_HIGH:   w_state_nxt = !w_bit_last ? S_SETUP : !w_io_last ? S_FETCH : S_LATCH;
      S_LATCH:  w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each is glitch-free for its whole state.
  always_comb begin
    w_shift_nxt = (r_state == S_FETCH) ? cfg_word :
                  (r_state == S_HIGH && !w_bit_last) ? (r_shift << 1) : r_shift;
    w_sclk_nxt  = (w_state_nxt == S_HIGH);
    w_load_nxt  = (w_state_nxt == S_LATCH);
    w_done_nxt  = (w_state_nxt == S_FINISH);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_sdo_nxt   = (w_state_nxt == S_SETUP) ? w_shift_nxt[CFG_BITS-1] : serial_data_out;
  end

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_io_idx        <= IO_LAST;
      r_bit_idx       <= BIT_LAST;
      r_shift         <= '0;
      serial_clock    <= 1'b0;
      serial_load     <= 1'b0;
      serial_data_out <= 1'b0;
      serial_resetn   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      r_shift         <= w_shift_nxt;
      serial_clock    <= w_sclk_nxt;
      serial_load     <= w_load_nxt;
      serial_data_out <= w_sdo_nxt;
      serial_resetn   <= 1'b1;
      busy            <= w_busy_nxt;
      done            <= w_done_nxt;
      if (r_state == S_HIGH) begin
        if (!w_bit_last) r_bit_idx <= r_bit_idx - BW'(1);
        else if (!w_io_last) begin
          r_io_idx  <= r_io_idx - AW'(1);
          r_bit_idx <= BIT_LAST;
        end
      end else if (r_state == S_LATCH) begin
        r_io_idx  <= IO_LAST;
        r_bit_idx <= BIT_LAST;
      end
    end
endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: default-size and 2x3 loaders run against a cycle-offset model of the transfer,
// plus directed checks of stream contents, hold-start, abort-by-reset and randomized traffic.
module tb_gpio_serial_loader;
  logic        clk = 1'b0;
  logic [1:0]  rn = 2'b00;
  logic [1:0]  xs = 2'b00;
  logic [12:0] wrd [2][19];
  wire  [4:0]  a0;
  wire         a1;
  wire  [12:0] w0;
  wire  [2:0]  w1;
  wire  [1:0]  sc, ld, sd, sr, bs, dn;
  int          n_chk = 0, n_fail = 0;
  int          m_t [2] = '{-1, -1};
  bit          m_sdo [2] = '{0, 0};
  bit          m_srst [2] = '{0, 0};
  bit          p_sc [2] = '{0, 0};
  bit          p_sd [2] = '{0, 0};
  bit          p_dn [2] = '{0, 0};
  int          rises [2] = '{0, 0};
  int          loads [2] = '{0, 0};
  int          bcyc [2] = '{0, 0};
  bit          q0[$], q1[$];

  assign w0 = wrd[0][a0];
  assign w1 = wrd[1][a1][2:0];

  always #5 clk = ~clk;

  gpio_serial_loader dut0 (
    .clock(clk), .resetn(rn[0]), .xfer_start(xs[0]), .cfg_addr(a0), .cfg_word(w0),
    .serial_clock(sc[0]), .serial_load(ld[0]), .serial_data_out(sd[0]),
    .serial_resetn(sr[0]), .busy(bs[0]), .done(dn[0]));

  gpio_serial_loader #(.NUM_IO(2), .CFG_BITS(3)) dut1 (
    .clock(clk), .resetn(rn[1]), .xfer_start(xs[1]), .cfg_addr(a1), .cfg_word(w1),
    .serial_clock(sc[1]), .serial_load(ld[1]), .serial_data_out(sd[1]),
    .serial_resetn(sr[1]), .busy(bs[1]), .done(dn[1]));

  function automatic int nio(input int i); return i ? 2 : 19; endfunction
  function automatic int cb(input int i); return i ? 3 : 13; endfunction
  function automatic int tlen(input int i); return nio(i) * (2 * cb(i) + 1) + 2; endfunction

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", i, nm, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the first FETCH; each GPIO takes 2*CFG_BITS+1 cycles
  // (one fetch, then a setup/high pair per bit), followed by one latch and one finish cycle.
  task automatic tick(input int i);
    int blk, o, k, j;
    if (!rn[i]) begin
      m_t[i] = -1; m_sdo[i] = 0; m_srst[i] = 0;
      return;
    end
    m_srst[i] = 1;
    if (m_t[i] < 0) m_t[i] = xs[i] ? 0 : -1;
    else m_t[i] = (m_t[i] == tlen(i) - 1) ? -1 : m_t[i] + 1;
    if (m_t[i] >= 0 && m_t[i] < tlen(i) - 2) begin
      blk = 2 * cb(i) + 1;
      o = m_t[i] % blk;
      k = nio(i) - 1 - m_t[i] / blk;
      j = (o - 1) / 2;
      if (o > 0 && (o - 1) % 2 == 0) m_sdo[i] = wrd[i][k][cb(i) - 1 - j];
    end
  endtask

  always @(posedge clk or negedge rn[0]) tick(0);
  always @(posedge clk or negedge rn[1]) tick(1);

  task automatic cmp(input int i, input logic [31:0] addr);
    int t, blk, L, o;
    bit hi;
    t = m_t[i]; blk = 2 * cb(i) + 1; L = tlen(i);
    o = (t >= 0) ? t % blk : 0;
    hi = (t >= 0 && t < L - 2 && o > 0 && (o - 1) % 2 == 1);
    chk(i, "serial_clock", sc[i], hi);
    chk(i, "serial_load", ld[i], t == L - 2);
    chk(i, "done", dn[i], t == L - 1);
    chk(i, "busy", bs[i], t >= 0);
    chk(i, "serial_data_out", sd[i], m_sdo[i]);
    chk(i, "serial_resetn", sr[i], m_srst[i]);
    if (t < L - 2) chk(i, "cfg_addr", addr, t < 0 ? nio(i) - 1 : nio(i) - 1 - t / blk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cmp(i, i ? 32'(a1) : 32'(a0));
      chk(i, "clk_load_exclusive", sc[i] & ld[i], 0);
      if (sc[i]) chk(i, "sdo_stable_while_high", sd[i], p_sd[i]);
      if (dn[i]) chk(i, "done_single_cycle", p_dn[i], 0);
      if (sc[i] && !p_sc[i]) begin
        rises[i]++;
        if (i == 0) q0.push_back(sd[0]);
        else q1.push_back(sd[1]);
      end
      loads[i] += int'(ld[i]);
      bcyc[i] += int'(bs[i]);
      p_sd[i] = sd[i]; p_sc[i] = sc[i]; p_dn[i] = dn[i];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin rises[i] = 0; loads[i] = 0; bcyc[i] = 0; end
    q0.delete();
    q1.delete();
  endtask

  task automatic wait_done(input int i, input int lim, output int n);
    n = 0;
    do begin step(); n++; end while (!dn[i] && n < lim);
    if (!dn[i]) chk(i, "done_timeout", 0, 1);
  endtask

  function automatic logic [12:0] word_at(input int base);
    logic [12:0] v = '0;
    for (int b = 0; b < 13; b++) v = {v[11:0], q0[base + b]};
    return v;
  endfunction

  initial begin
    int n;
    logic [5:0] v1;
    for (int k = 0; k < 19; k++) begin wrd[0][k] = 13'h1000 | 13'(k); wrd[1][k] = '0; end
    wrd[1][0] = 13'b101;
    wrd[1][1] = 13'b010;
    repeat (3) step();
    chk(0, "reset_serial_resetn", sr[0], 0);
    chk(0, "reset_cfg_addr", a0, 18);
    chk(1, "reset_busy", bs[1], 0);
    rn = 2'b11;
    #1;
    chk(0, "serial_resetn_before_edge", sr[0], 0);
    step();
    chk(0, "serial_resetn_after_edge", sr[0], 1);
    chk(1, "serial_resetn_after_edge", sr[1], 1);

    // single-pulse transfer on both sizes
    clr();
    xs = 2'b11;
    step();
    xs = 2'b00;
    wait_done(0, 600, n);
    chk(0, "done_cycle", n + 1, 515);
    step();
    chk(0, "clock_rises", rises[0], 247);
    chk(0, "load_pulses", loads[0], 1);
    chk(0, "busy_cycles", bcyc[0], 515);
    chk(0, "stream_len", q0.size(), 247);
    if (q0.size() == 247) begin
      chk(0, "first_word", word_at(0), 13'h1012);
      chk(0, "word_9", word_at(9 * 13), 13'h1009);
      chk(0, "last_word", word_at(234), 13'h1000);
    end
    chk(1, "clock_rises", rises[1], 6);
    chk(1, "busy_cycles", bcyc[1], 16);
    chk(1, "load_pulses", loads[1], 1);
    v1 = '0;
    foreach (q1[b]) v1 = {v1[4:0], q1[b]};
    chk(1, "stream_bits", v1, 6'b010101);

    // start held high: one transfer, one idle cycle, then a second transfer
    clr();
    xs[0] = 1'b1;
    wait_done(0, 600, n);
    step();
    chk(0, "idle_between_transfers", bs[0], 0);
    step();
    chk(0, "second_transfer_started", bs[0], 1);
    xs[0] = 1'b0;
    wait_done(0, 600, n);
    step();
    chk(0, "hold_load_pulses", loads[0], 2);
    chk(0, "hold_clock_rises", rises[0], 494);

    // abort by asynchronous reset at cycle 200
    for (int k = 0; k < 19; k++) wrd[0][k] = 13'($urandom);
    clr();
    xs[0] = 1'b1;
    step();
    xs[0] = 1'b0;
    repeat (199) step();
    @(posedge clk);
    #2 rn[0] = 1'b0;
    #1;
    chk(0, "abort_outputs", {sc[0], ld[0], sd[0], bs[0], dn[0]}, 0);
    chk(0, "abort_serial_resetn", sr[0], 0);
    chk(0, "abort_cfg_addr", a0, 18);
    repeat (3) step();
    rn[0] = 1'b1;
    #1;
    chk(0, "release_serial_resetn_low", sr[0], 0);
    step();
    chk(0, "release_serial_resetn_high", sr[0], 1);
    repeat (5) step();
    chk(0, "abort_no_load", loads[0], 0);
    chk(0, "abort_no_restart", bs[0], 0);

    // randomized starts, including ignored starts while busy and new words between transfers
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_t[i] < 0 && $urandom_range(0, 3) == 0)
          for (int k = 0; k < 19; k++) wrd[i][k] = i ? 13'($urandom_range(0, 7)) : 13'($urandom);
        xs[i] = ($urandom_range(0, 15) == 0);
      end
      step();
    end
    xs = 2'b00;
    n = 0;
    while (bs != 2'b00 && n < 600) begin step(); n++; end
    if (bs != 2'b00) chk(0, "drain_timeout", 32'(bs), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
